// File: rtl/multdiv_seq_ctrl_if.sv
// Handshake bundle between the mul/div issue logic and the step sequencer.
// Master drives start/stall/flush; slave (the sequencer) drives the step decodes.
interface multdiv_seq_ctrl_if #(
  parameter int unsigned CNT_W = 6
);
  logic             ctrl_MULT;
  logic             ctrl_DIV;
  logic             stall;
  logic             flush;
  logic             busy;
  logic             op_div;
  logic [CNT_W-1:0] count;
  logic             step_first;
  logic             step_last;
  logic             ready;

  modport master (
    output ctrl_MULT, ctrl_DIV, stall, flush,
    input  busy, op_div, count, step_first, step_last, ready
  );

  modport slave (
    input  ctrl_MULT, ctrl_DIV, stall, flush,
    output busy, op_div, count, step_first, step_last, ready
  );
endinterface

// File: rtl/multdiv_seq_ctrl.sv
// Step sequencer for the multi-cycle multiply/divide datapath: IDLE -> RUN (N steps) -> DONE.
// Outputs are decoded only from registered state, count and operation.
module multdiv_seq_ctrl #(
  parameter int unsigned CNT_W       = 6,
  parameter int unsigned MULT_CYCLES = 32,
  parameter int unsigned DIV_CYCLES  = 32
) (
  input  logic                clock,
  input  logic                reset,
  multdiv_seq_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] MULT_LAST = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV_CYCLES - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_count;
  logic             r_op_div;

  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_count_nxt;
  logic             w_op_div_nxt;
  logic             w_start;
  logic             w_start_div;
  logic [CNT_W-1:0] w_last;

  // Multiply wins when both start pulses coincide.
  assign w_start     = bus.ctrl_MULT | bus.ctrl_DIV;
  assign w_start_div = bus.ctrl_DIV & ~bus.ctrl_MULT;
  assign w_last      = r_op_div ? DIV_LAST : MULT_LAST;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_count  <= '0;
      r_op_div <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_count  <= w_count_nxt;
      r_op_div <= w_op_div_nxt;
    end
  end

  // Next-state: flush > start > stall > advance.
  always_comb begin
    w_state_nxt  = r_state;
    w_count_nxt  = r_count;
    w_op_div_nxt = r_op_div;
    unique case (r_state)
      S_IDLE: begin
        w_count_nxt = '0;
        if (!bus.flush && w_start) begin
          w_state_nxt  = S_RUN;
          w_op_div_nxt = w_start_div;
        end
      end
      S_RUN: begin
        if (bus.flush) begin
          w_state_nxt = S_IDLE;
          w_count_nxt = '0;
        end else if (w_start) begin
          w_count_nxt  = '0;
          w_op_div_nxt = w_start_div;
        end else if (!bus.stall) begin
          if (r_count == w_last) begin
            w_state_nxt = S_DONE;
            w_count_nxt = '0;
          end else begin
            w_count_nxt = r_count + CNT_W'(1);
          end
        end
      end
      S_DONE: begin
        w_count_nxt = '0;
        if (!bus.flush && w_start) begin
          w_state_nxt  = S_RUN;
          w_op_div_nxt = w_start_div;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_count_nxt = '0;
      end
    endcase
  end

  assign bus.busy       = (r_state == S_RUN);
  assign bus.op_div     = r_op_div;
  assign bus.count      = r_count;
  assign bus.step_first = (r_state == S_RUN) && (r_count == '0);
  assign bus.step_last  = (r_state == S_RUN) && (r_count == w_last);
  assign bus.ready      = (r_state == S_DONE);

endmodule
